apb_reg_slave: RTL and testbench
================================

APB_REG_SLAVE -- requirements
Module: apb_reg_slave

Interface
REQ-001 SHALL have parameter SLAVE_ID, default 1; the value of sel[1:0] that selects this slave.
REQ-002 SHALL have parameter RESET_VAL, default 8'h00; the reset value of every register-bank entry.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port sel  input  2  APB slave select; the slave is selected when sel == SLAVE_ID.
REQ-006 SHALL have port enable  input  1  APB access-phase indicator.
REQ-007 SHALL have port write  input  1  1 = write, 0 = read.
REQ-008 SHALL have port addr  input  8  byte address.
REQ-009 SHALL have port wdata  input  8  write data.
REQ-010 SHALL have port rdata  output  8  read data.
REQ-011 SHALL have port ready  output  1  transfer-complete / no-wait indicator.

Function
REQ-012 SHALL contain a 16 x 8-bit register bank at addresses 0x00-0x0F; addresses 0x10-0xFF are out of range.
REQ-013 SHALL implement the FSM states IDLE, WAIT and ACCESS.
REQ-014 SHALL treat a cycle in IDLE with sel==SLAVE_ID and enable==0 as a setup phase, and SHALL latch addr, write and wdata into addr_q, write_q and wdata_q at that edge.
REQ-015 SHALL transition IDLE to ACCESS on the setup edge when wait_cfg==0, and IDLE to WAIT with cnt=wait_cfg when wait_cfg>0.
REQ-016 SHALL, in WAIT, decrement cnt each edge and go to ACCESS on the edge where cnt==1; this gives exactly wait_cfg cycles with ready=0 before ACCESS.
REQ-017 SHALL drive ready=1 only in ACCESS, and 0 in every other state.
REQ-018 SHALL, in ACCESS with write_q=1 and addr_q in range, write wdata_q to mem[addr_q[3:0]] at the closing edge; out-of-range writes SHALL be discarded.
REQ-019 SHALL, in ACCESS with write_q=0, drive rdata=mem[addr_q[3:0]] (0x00 if addr_q is out of range); rdata SHALL be 0x00 in all other cycles.
REQ-020 SHALL go from ACCESS to IDLE unconditionally; a back-to-back setup in the following cycle SHALL be accepted from IDLE (single-cycle gap, no lost transfer).
REQ-021 SHALL abort to IDLE without a write when sel!=SLAVE_ID or enable==0 is sampled in WAIT or ACCESS.
REQ-022 SHALL ignore enable==1 with a matching sel while in IDLE (no setup seen): no state change, ready stays 0.
REQ-023 SHALL make a write to the wait register take effect from the next transfer only; the count of an in-flight transfer SHALL be unaffected.

Reset
REQ-024 SHALL, on an edge with reset==0, go to IDLE, set all mem entries to RESET_VAL, set wait_cfg=0 and cnt=0, and give ready=0 and rdata=0x00 in the following cycle.
REQ-025 SHALL, on reset during WAIT or ACCESS, discard the pending write.

Configuration
REQ-026 SHALL, with APB_SLAVE_WAIT_EN defined, alias mem[0x0F][2:0] as wait_cfg (0-7 wait states); bits [7:3] SHALL be ordinary storage.
REQ-027 SHALL, with APB_SLAVE_WAIT_EN undefined, hold wait_cfg at constant 0, omit the WAIT state, keep 0x0F as an ordinary register, and complete every transfer with zero wait states.

Verification
REQ-028 SHALL cover a zero-wait write: setup with addr=0x06, wdata=0x05 -> ready=1 in the first enable cycle and mem[6]=0x05.
REQ-029 SHALL cover a zero-wait read: setup with addr=0x06, write=0 -> in the enable cycle ready=1 and rdata=0x05; rdata=0x00 in the cycle after.
REQ-030 SHALL cover programmed wait states (WAIT_EN): write 0x05 to 0x0F, then write 0x04 to 0x05 -> exactly 5 enable cycles with ready=0, ready=1 in the 6th, and mem[5]=0x04.
REQ-031 SHALL cover out-of-range and foreign select: write 0x77 to 0x20 -> no mem change, and a read returns 0x00; a transfer with sel=2 -> ready stays 0 and no mem change.
REQ-032 SHALL cover abort and reset: drop sel in the 2nd WAIT cycle -> IDLE, no write; reset==0 mid-WAIT -> ready=0, rdata=0x00, all mem=RESET_VAL.
REQ-033 SHALL cover back-to-back transfers: a write then a read to 0x03 with setup immediately after ACCESS -> both complete, and the read returns the written value.

Source files
------------

// File: rtl/apb_reg_slave.sv
// APB register slave: 16 x 8-bit register bank, IDLE/WAIT/ACCESS handshake.
// Define APB_SLAVE_WAIT_EN to alias mem[0x0F][2:0] as the programmable wait-state count.
module apb_reg_slave #(
  parameter logic [1:0] SLAVE_ID  = 2'd1,
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] sel,
  input  logic       enable,
  input  logic       write,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       ready
);

`ifdef APB_SLAVE_WAIT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, ACCESS = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd2} state_t;
`endif

  state_t      state;
  logic [7:0]  mem [16];
  logic [7:0]  addr_q;
  logic [7:0]  wdata_q;
  logic        write_q;
  logic        selected;
  logic [7:0]  rd_setup;
  logic [7:0]  rd_held;

`ifdef APB_SLAVE_WAIT_EN
  logic [2:0]  wait_cfg;
  logic [2:0]  cnt;

  assign wait_cfg = mem[15][2:0];
`endif

  function automatic logic in_range(input logic [7:0] a);
    return (a[7:4] == 4'h0);
  endfunction

  assign selected = (sel == SLAVE_ID);

  // Read word for an access entered straight from setup, and for one entered after waiting.
  assign rd_setup = (!write   && in_range(addr))   ? mem[addr[3:0]]   : 8'h00;
  assign rd_held  = (!write_q && in_range(addr_q)) ? mem[addr_q[3:0]] : 8'h00;

  // ready and rdata are registered: they are loaded on the edge that enters ACCESS
  // and cleared on every other edge, so ready is high exactly while in ACCESS.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      ready <= 1'b0;
      rdata <= 8'h00;
      for (int i = 0; i < 16; i++) begin
        mem[i] <= RESET_VAL;
      end
`ifdef APB_SLAVE_WAIT_EN
      // The wait count must come out of reset as zero, whatever RESET_VAL holds.
      mem[15][2:0] <= 3'd0;
      cnt          <= 3'd0;
`endif
    end else begin
      ready <= 1'b0;
      rdata <= 8'h00;
      case (state)
        IDLE: begin
          if (selected && !enable) begin
            addr_q  <= addr;
            write_q <= write;
            wdata_q <= wdata;
`ifdef APB_SLAVE_WAIT_EN
            if (wait_cfg != 3'd0) begin
              state <= WAIT;
              cnt   <= wait_cfg;
            end else begin
              state <= ACCESS;
              ready <= 1'b1;
              rdata <= rd_setup;
            end
`else
            state <= ACCESS;
            ready <= 1'b1;
            rdata <= rd_setup;
`endif
          end
        end
`ifdef APB_SLAVE_WAIT_EN
        WAIT: begin
          if (!selected || !enable) begin
            state <= IDLE;
          end else if (cnt == 3'd1) begin
            state <= ACCESS;
            ready <= 1'b1;
            rdata <= rd_held;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
`endif
        ACCESS: begin
          state <= IDLE;
          if (selected && enable && write_q && in_range(addr_q)) begin
            mem[addr_q[3:0]] <= wdata_q;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_reg_slave.sv
// Directed bench for apb_reg_slave; builds with or without APB_SLAVE_WAIT_EN.
`timescale 1ns/1ps
module tb_apb_reg_slave;

  logic       clk;
  logic       reset;
  logic [1:0] sel;
  logic       enable;
  logic       write;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       ready;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef APB_SLAVE_WAIT_EN
  localparam int PROG_WAITS = 5;
  localparam int ABORT_WAITS = 3;
`else
  localparam int PROG_WAITS = 0;
  localparam int ABORT_WAITS = 0;
`endif

  apb_reg_slave #(.SLAVE_ID(2'd1), .RESET_VAL(8'h00)) dut (
    .clk    (clk),
    .reset  (reset),
    .sel    (sel),
    .enable (enable),
    .write  (write),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .ready  (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One APB transfer; returns whether ready was seen, the rdata in that cycle,
  // and the number of enable cycles with ready low. Ends with the bus idle.
  task automatic apb_xfer(input logic [1:0] s, input logic w, input logic [7:0] a,
                          input logic [7:0] d, output logic got_ready,
                          output logic [7:0] rd, output int waits);
    sel = s; enable = 1'b0; write = w; addr = a; wdata = d;
    @(posedge clk); #1;
    enable = 1'b1;
    got_ready = 1'b0; rd = 8'hxx; waits = 0;
    for (int i = 0; i < 12 && !got_ready; i++) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        got_ready = 1'b1;
        rd = rdata;
      end else begin
        waits++;
      end
      @(posedge clk); #1;
    end
    sel = 2'd0; enable = 1'b0;
  endtask

  task automatic test_reset();
    logic g; logic [7:0] rd; int w;
    reset = 1'b0; sel = 2'd0; enable = 1'b0; write = 1'b0; addr = 8'h00; wdata = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b, expected 0", ready); end
    n_checks++;
    if (rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %h, expected 00", rdata); end
    @(posedge clk); #1;
    reset = 1'b1;
    apb_xfer(2'd1, 1'b0, 8'h06, 8'h00, g, rd, w);
    n_checks++;
    if (rd !== 8'h00) begin n_fail++; $display("FAIL reset_mem6: got %h, expected 00", rd); end
    apb_xfer(2'd1, 1'b0, 8'h0F, 8'h00, g, rd, w);
    n_checks++;
    if (rd !== 8'h00) begin n_fail++; $display("FAIL reset_memF: got %h, expected 00", rd); end
    n_checks++;
    if (w !== 0) begin n_fail++; $display("FAIL reset_waitcfg: got %0d waits, expected 0", w); end
  endtask

  task automatic test_idle_enable();
    sel = 2'd1; enable = 1'b1; write = 1'b1; addr = 8'h02; wdata = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (ready !== 1'b0) begin n_fail++; $display("FAIL idle_enable_ready[%0d]: got %b, expected 0", i, ready); end
    end
    @(posedge clk); #1;
    sel = 2'd0; enable = 1'b0;
  endtask

  task automatic test_zero_wait();
    logic g; logic [7:0] rd; int w;
    apb_xfer(2'd1, 1'b1, 8'h06, 8'h05, g, rd, w);
    n_checks++;
    if (g !== 1'b1 || w !== 0) begin n_fail++; $display("FAIL zw_write: ready=%b waits=%0d, expected ready=1 waits=0", g, w); end
    apb_xfer(2'd1, 1'b0, 8'h06, 8'h00, g, rd, w);
    n_checks++;
    if (g !== 1'b1 || w !== 0) begin n_fail++; $display("FAIL zw_read_ready: ready=%b waits=%0d, expected ready=1 waits=0", g, w); end
    n_checks++;
    if (rd !== 8'h05) begin n_fail++; $display("FAIL zw_read_data: got %h, expected 05", rd); end
    @(negedge clk);
    n_checks++;
    if (rdata !== 8'h00 || ready !== 1'b0) begin
      n_fail++; $display("FAIL zw_after: rdata=%h ready=%b, expected 00/0", rdata, ready);
    end
    apb_xfer(2'd1, 1'b0, 8'h02, 8'h00, g, rd, w);
    n_checks++;
    if (rd !== 8'h00) begin n_fail++; $display("FAIL idle_enable_nowrite: got %h, expected 00", rd); end
  endtask

  task automatic test_wait_states();
    logic g; logic [7:0] rd; int w;
    apb_xfer(2'd1, 1'b1, 8'h0F, 8'h05, g, rd, w);
    n_checks++;
    if (w !== 0) begin n_fail++; $display("FAIL ws_cfg_write: got %0d waits, expected 0", w); end
    apb_xfer(2'd1, 1'b1, 8'h05, 8'h04, g, rd, w);
    n_checks++;
    if (g !== 1'b1 || w !== PROG_WAITS) begin
      n_fail++; $display("FAIL ws_write: ready=%b waits=%0d, expected ready=1 waits=%0d", g, w, PROG_WAITS);
    end
    apb_xfer(2'd1, 1'b0, 8'h05, 8'h00, g, rd, w);
    n_checks++;
    if (rd !== 8'h04) begin n_fail++; $display("FAIL ws_read5: got %h, expected 04", rd); end
    apb_xfer(2'd1, 1'b0, 8'h0F, 8'h00, g, rd, w);
    n_checks++;
    if (rd !== 8'h05) begin n_fail++; $display("FAIL ws_readF: got %h, expected 05", rd); end
    // Clearing the count still waits on this transfer; the next one is back to zero.
    apb_xfer(2'd1, 1'b1, 8'h0F, 8'h00, g, rd, w);
    n_checks++;
    if (w !== PROG_WAITS) begin n_fail++; $display("FAIL ws_clear_inflight: got %0d waits, expected %0d", w, PROG_WAITS); end
    apb_xfer(2'd1, 1'b0, 8'h05, 8'h00, g, rd, w);
    n_checks++;
    if (w !== 0 || rd !== 8'h04) begin n_fail++; $display("FAIL ws_after_clear: waits=%0d rd=%h, expected 0/04", w, rd); end
  endtask

  task automatic test_out_of_range();
    logic g; logic [7:0] rd; int w;
    apb_xfer(2'd1, 1'b1, 8'h20, 8'h77, g, rd, w);
    n_checks++;
    if (g !== 1'b1) begin n_fail++; $display("FAIL oor_write_ready: got %b, expected 1", g); end
    apb_xfer(2'd1, 1'b0, 8'h20, 8'h00, g, rd, w);
    n_checks++;
    if (rd !== 8'h00) begin n_fail++; $display("FAIL oor_read: got %h, expected 00", rd); end
    apb_xfer(2'd1, 1'b0, 8'h00, 8'h00, g, rd, w);
    n_checks++;
    if (rd !== 8'h00) begin n_fail++; $display("FAIL oor_alias0: got %h, expected 00", rd); end
    apb_xfer(2'd2, 1'b1, 8'h06, 8'h99, g, rd, w);
    n_checks++;
    if (g !== 1'b0) begin n_fail++; $display("FAIL foreign_ready: got %b, expected 0", g); end
    apb_xfer(2'd1, 1'b0, 8'h06, 8'h00, g, rd, w);
    n_checks++;
    if (rd !== 8'h05) begin n_fail++; $display("FAIL foreign_nowrite: got %h, expected 05", rd); end
  endtask

  task automatic test_abort();
    logic g; logic [7:0] rd; int w;
    // Drop sel in the access cycle: no write must land.
    sel = 2'd1; enable = 1'b0; write = 1'b1; addr = 8'h07; wdata = 8'hAA;
    @(posedge clk); #1;
    enable = 1'b1; sel = 2'd0;
    @(posedge clk); #1;
    enable = 1'b0;
    apb_xfer(2'd1, 1'b0, 8'h07, 8'h00, g, rd, w);
    n_checks++;
    if (rd !== 8'h00) begin n_fail++; $display("FAIL abort_access: got %h, expected 00", rd); end
`ifdef APB_SLAVE_WAIT_EN
    apb_xfer(2'd1, 1'b1, 8'h0F, 8'h03, g, rd, w);
    sel = 2'd1; enable = 1'b0; write = 1'b1; addr = 8'h08; wdata = 8'hBB;
    @(posedge clk); #1;
    enable = 1'b1;
    @(posedge clk); #1;
    sel = 2'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (ready !== 1'b0) begin n_fail++; $display("FAIL abort_wait_ready[%0d]: got %b, expected 0", i, ready); end
      @(posedge clk); #1;
      enable = 1'b0;
    end
    apb_xfer(2'd1, 1'b0, 8'h08, 8'h00, g, rd, w);
    n_checks++;
    if (rd !== 8'h00 || w !== 3) begin n_fail++; $display("FAIL abort_wait_nowrite: rd=%h waits=%0d, expected 00/3", rd, w); end
    apb_xfer(2'd1, 1'b1, 8'h0F, 8'h00, g, rd, w);
`endif
  endtask

  task automatic test_back_to_back();
    logic g1, g2; logic [7:0] rd1, rd2; int w1, w2;
    apb_xfer(2'd1, 1'b1, 8'h03, 8'h3C, g1, rd1, w1);
    apb_xfer(2'd1, 1'b0, 8'h03, 8'h00, g2, rd2, w2);
    n_checks++;
    if (g1 !== 1'b1 || g2 !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b/%b, expected 1/1", g1, g2); end
    n_checks++;
    if (rd2 !== 8'h3C) begin n_fail++; $display("FAIL b2b_read: got %h, expected 3c", rd2); end
  endtask

  task automatic test_reset_mid();
    logic g; logic [7:0] rd; int w;
`ifdef APB_SLAVE_WAIT_EN
    apb_xfer(2'd1, 1'b1, 8'h0F, 8'h03, g, rd, w);
`endif
    sel = 2'd1; enable = 1'b0; write = 1'b1; addr = 8'h09; wdata = 8'h11;
    @(posedge clk); #1;
    enable = 1'b1;
    for (int i = 0; i < ABORT_WAITS - 1; i++) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (ready !== 1'b0 || rdata !== 8'h00) begin
      n_fail++; $display("FAIL reset_mid_out: ready=%b rdata=%h, expected 0/00", ready, rdata);
    end
    @(posedge clk); #1;
    reset = 1'b1; sel = 2'd0; enable = 1'b0;
    apb_xfer(2'd1, 1'b0, 8'h06, 8'h00, g, rd, w);
    n_checks++;
    if (rd !== 8'h00) begin n_fail++; $display("FAIL reset_mid_mem6: got %h, expected 00", rd); end
    apb_xfer(2'd1, 1'b0, 8'h03, 8'h00, g, rd, w);
    n_checks++;
    if (rd !== 8'h00) begin n_fail++; $display("FAIL reset_mid_mem3: got %h, expected 00", rd); end
    apb_xfer(2'd1, 1'b0, 8'h09, 8'h00, g, rd, w);
    n_checks++;
    if (rd !== 8'h00 || w !== 0) begin n_fail++; $display("FAIL reset_mid_mem9: rd=%h waits=%0d, expected 00/0", rd, w); end
  endtask

  initial begin
    test_reset();
    test_idle_enable();
    test_zero_wait();
    test_wait_states();
    test_out_of_range();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
